// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port.
// One request is accepted at a time, held for LATENCY wait cycles, then the
// word array is accessed and a response is presented until the requester
// takes it. Every output is driven from a register.
module dmem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int LANES = DATA_W / 8;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              latch_en;
  logic              do_access;

  // Request captured at accept; later input changes must not leak in
  logic              we_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [LANES-1:0]  wstrb_p0;

  // Access operands: with zero latency the access happens on the accept
  // edge itself, so the live request inputs are used instead of the latch
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [LANES-1:0]  acc_wstrb;
  logic              acc_err;
  logic [IDX_W-1:0]  acc_idx;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  assign acc_we    = (state_q == IDLE) ? req_we    : we_p0;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_p0;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_p0;
  assign acc_wstrb = (state_q == IDLE) ? req_wstrb : wstrb_p0;
  assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[ADDR_W-1:2] >= DEPTH_LIM);
  assign acc_idx   = acc_addr[IDX_W+1:2];

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Control and response registers; reset aborts any in-flight request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic for the accept/wait/respond sequence
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    valid_d   = valid_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    latch_en  = 1'b0;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          latch_en = 1'b1;
          ready_d  = 1'b0;
          if (LATENCY == 0) begin
            do_access = 1'b1;
            state_d   = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          do_access = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (valid_q && rsp_ready) begin
          valid_d = 1'b0;
          err_d   = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (do_access) begin
      valid_d = 1'b1;
      err_d   = acc_err;
      rdata_d = (acc_err || acc_we) ? '0 : mem[acc_idx];
    end
  end

  // Capture the request fields on the accept edge
  always_ff @(posedge clk) begin
    if (latch_en) begin
      we_p0    <= req_we;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
      wstrb_p0 <= req_wstrb;
    end
  end

  // Store commit: only strobed lanes of an in-range, aligned word are written
  always_ff @(posedge clk) begin
    if (do_access && acc_we && !acc_err) begin
      for (int i = 0; i < LANES; i++) begin
        if (acc_wstrb[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance carries most of the
// scenarios, a LATENCY=0 instance covers the zero-wait response timing.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        req_valid0 = 1'b0;
  logic        req_ready0;
  logic        req_we0 = 1'b0;
  logic [31:0] req_addr0 = '0;
  logic [31:0] req_wdata0 = '0;
  logic [3:0]  req_wstrb0 = '0;
  logic        rsp_valid0;
  logic        rsp_ready0 = 1'b0;
  logic [31:0] rsp_rdata0;
  logic        rsp_err0;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(256), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(256), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_wstrb(req_wstrb0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 instance. lat counts negedge
  // samples after the accept edge until rsp_valid is seen (1 + LATENCY).
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, output logic [31:0] rdata,
                      output logic err, output int latency);
    @(negedge clk);
    check("pre_req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFF;
    req_wdata = ~wdata; req_wstrb = ~wstrb;
    latency = 99;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        latency = k;
        break;
      end
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("post_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    // Reset held for two cycles
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b1;
    #1;
    check("rel_req_ready_before_edge", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("rel_req_ready_after_edge", {31'd0, req_ready}, 32'd1);
    check("rel_req_ready0_after_edge", {31'd0, req_ready0}, 32'd1);

    // Full-word store then load
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check("st10_latency", lat, 32'd3);
    check("st10_err", {31'd0, er}, 32'd0);
    check("st10_rdata", rd, 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("ld10_latency", lat, 32'd3);
    check("ld10_err", {31'd0, er}, 32'd0);
    check("ld10_rdata", rd, 32'hDEADBEEF);

    // Partial store into lane 1 only
    xact(1'b1, 32'h10, 32'h0000AA00, 4'b0010, rd, er, lat);
    check("pst10_err", {31'd0, er}, 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("pld10_rdata", rd, 32'hDEADAAEF);

    // Zero-strobe store is a legal no-op
    xact(1'b1, 32'h10, 32'h55555555, 4'h0, rd, er, lat);
    check("z_st_err", {31'd0, er}, 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("z_ld10_rdata", rd, 32'hDEADAAEF);

    // Error cases: misaligned load, out-of-range store
    xact(1'b1, 32'h3FC, 32'h12345678, 4'hF, rd, er, lat);
    xact(1'b1, 32'h0, 32'h0BADF00D, 4'hF, rd, er, lat);
    xact(1'b0, 32'h11, 32'h0, 4'h0, rd, er, lat);
    check("mis_ld_err", {31'd0, er}, 32'd1);
    check("mis_ld_rdata", rd, 32'd0);
    check("mis_ld_latency", lat, 32'd3);
    xact(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    check("oor_st_err", {31'd0, er}, 32'd1);
    check("oor_st_rdata", rd, 32'd0);
    xact(1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
    check("oor_ld3fc_rdata", rd, 32'h12345678);
    check("oor_ld3fc_err", {31'd0, er}, 32'd0);
    xact(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    check("oor_ld0_rdata", rd, 32'h0BADF00D);

    // Backpressure: response held, competing request ignored
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h3FC; req_wdata = '0; req_wstrb = '0;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFFFFFF; req_wstrb = 4'hF;
    repeat (3) @(negedge clk);
    check("bp_valid_arrives", {31'd0, rsp_valid}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'h12345678);
      check("bp_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    check("bp_release_ready", {31'd0, req_ready}, 32'd1);
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("bp_ignored_store", rd, 32'hDEADAAEF);

    // Reset during WAIT discards the uncommitted store
    xact(1'b1, 32'h20, 32'h11111111, 4'hF, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h22222222; req_wstrb = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    check("midrst_held_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready_back", {31'd0, req_ready}, 32'd1);
    xact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    check("midrst_ld20_rdata", rd, 32'h11111111);

    // Zero-latency instance: response on the edge after accept
    @(negedge clk);
    check("l0_pre_ready", {31'd0, req_ready0}, 32'd1);
    req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 32'h20;
    req_wdata0 = 32'hCAFEF00D; req_wstrb0 = 4'hF;
    @(posedge clk); #1;
    req_valid0 = 1'b0; req_addr0 = 32'h24; req_wdata0 = 32'h0;
    @(negedge clk);
    check("l0_st_valid", {31'd0, rsp_valid0}, 32'd1);
    check("l0_st_err", {31'd0, rsp_err0}, 32'd0);
    check("l0_st_ready", {31'd0, req_ready0}, 32'd0);
    rsp_ready0 = 1'b1;
    @(posedge clk); #1;
    rsp_ready0 = 1'b0;
    @(negedge clk);
    check("l0_st_done_valid", {31'd0, rsp_valid0}, 32'd0);
    check("l0_st_done_ready", {31'd0, req_ready0}, 32'd1);
    req_valid0 = 1'b1; req_we0 = 1'b0; req_addr0 = 32'h20; req_wstrb0 = 4'h0;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    @(negedge clk);
    check("l0_ld_valid", {31'd0, rsp_valid0}, 32'd1);
    check("l0_ld_rdata", rsp_rdata0, 32'hCAFEF00D);
    check("l0_ld_err", {31'd0, rsp_err0}, 32'd0);
    rsp_ready0 = 1'b1;
    @(posedge clk); #1;
    rsp_ready0 = 1'b0;
    @(negedge clk);
    check("l0_ld_done_valid", {31'd0, rsp_valid0}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
